// File: rtl/noc_output_arbiter.sv
// rtl/noc_output_arbiter.sv - wormhole round-robin output arbiter with per-requester grant counters
// One instance per router output port; the grant is held from first to last flit of a packet.
module noc_output_arbiter #(
  parameter int PORTS  = 3,
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16,
  parameter int SRC_W  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [PORTS-1:0]          req_valid,
  input  logic [PORTS-1:0]          req_last,
  input  logic [PORTS*DATA_W-1:0]   req_data,
  output logic [PORTS-1:0]          req_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_last,
  input  logic                      out_ready,
  output logic [SRC_W-1:0]          out_src,
  output logic                      busy,
  input  logic                      clr_stats,
  output logic [PORTS*CNT_W-1:0]    grant_cnt
);

  localparam logic [0:0]       S_IDLE   = 1'b0;
  localparam logic [0:0]       S_LOCKED = 1'b1;
  localparam logic [SRC_W-1:0] RR_RESET = SRC_W'(PORTS - 1);

  logic [0:0]                        state_q, state_d;
  logic [SRC_W-1:0]                  gnt_q, gnt_d;
  logic [SRC_W-1:0]                  rr_ptr_q, rr_ptr_d;
  logic [PORTS-1:0][CNT_W-1:0]       cnt_q, cnt_d;

  logic                              locked;
  logic                              scan_hit;
  logic [SRC_W-1:0]                  scan_idx;
  int                                scan_best;
  logic                              sel_valid;
  logic                              sel_last;
  logic [DATA_W-1:0]                 sel_data;
  logic                              xfer_last;

  assign locked = (state_q == S_LOCKED);

  // Lowest cyclic distance from rr_ptr+1 wins, so the last owner has the lowest priority.
  always_comb begin
    scan_hit  = 1'b0;
    scan_idx  = '0;
    scan_best = PORTS;
    for (int i = 0; i < PORTS; i++) begin
      if (req_valid[i] && (((i + 2 * PORTS - int'(rr_ptr_q) - 1) % PORTS) < scan_best)) begin
        scan_best = (i + 2 * PORTS - int'(rr_ptr_q) - 1) % PORTS;
        scan_hit  = 1'b1;
        scan_idx  = SRC_W'(i);
      end
    end
  end

  // Explicit select keeps non-granted flits (and any X on them) off the output.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (gnt_q == SRC_W'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign out_valid = locked & sel_valid;
  assign out_last  = out_valid & sel_last;
  assign out_data  = out_valid ? sel_data : '0;
  assign busy      = locked;
  assign out_src   = locked ? gnt_q : '0;
  assign xfer_last = out_valid & out_ready & out_last;
  assign grant_cnt = cnt_q;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < PORTS; i++) begin
      req_ready[i] = locked && (gnt_q == SRC_W'(i)) && out_ready;
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      S_IDLE: begin
        if (scan_hit) begin
          gnt_d   = scan_idx;
          state_d = S_LOCKED;
        end
      end
      S_LOCKED: begin
        if (xfer_last) begin
          state_d  = S_IDLE;
          rr_ptr_d = gnt_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Clear takes precedence over a coincident grant; counters saturate instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < PORTS; i++) begin
      if (clr_stats) begin
        cnt_d[i] = '0;
      end else if (!locked && scan_hit && (scan_idx == SRC_W'(i)) && (cnt_q[i] != {CNT_W{1'b1}})) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      gnt_q    <= '0;
      rr_ptr_q <= RR_RESET;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_noc_output_arbiter.sv
// tb/tb_noc_output_arbiter.sv - directed scenarios plus randomized run against a packet-level model
module tb_noc_output_arbiter;

  localparam int P   = 3;
  localparam int DW  = 64;
  localparam int CW  = 16;
  localparam int CWS = 2;
  localparam int SW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [P-1:0]      req_valid;
  logic [P-1:0]      req_last;
  logic [P*DW-1:0]   req_data;
  logic [P-1:0]      req_ready;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic              out_last;
  logic              out_ready;
  logic [SW-1:0]     out_src;
  logic              busy;
  logic              clr_stats;
  logic [P*CW-1:0]   grant_cnt;

  logic [P-1:0]      s_req_ready;
  logic              s_out_valid;
  logic [DW-1:0]     s_out_data;
  logic              s_out_last;
  logic [SW-1:0]     s_out_src;
  logic              s_busy;
  logic [P*CWS-1:0]  s_grant_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  noc_output_arbiter #(.PORTS(P), .DATA_W(DW), .CNT_W(CW), .SRC_W(SW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .out_src(out_src), .busy(busy), .clr_stats(clr_stats),
    .grant_cnt(grant_cnt)
  );

  // Narrow-counter twin sharing all inputs, so saturation is reachable in a few grants.
  noc_output_arbiter #(.PORTS(P), .DATA_W(DW), .CNT_W(CWS), .SRC_W(SW)) dut_s (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(s_req_ready), .out_valid(s_out_valid), .out_data(s_out_data), .out_last(s_out_last),
    .out_ready(out_ready), .out_src(s_out_src), .busy(s_busy), .clr_stats(clr_stats),
    .grant_cnt(s_grant_cnt)
  );

  int m_owner = -1;
  int m_rr    = P - 1;
  int m_cnt [P];

  function automatic int pick(input int rr, input logic [P-1:0] v);
    for (int off = 1; off <= P; off++) begin
      if (v[(rr + off) % P]) return (rr + off) % P;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_owner <= -1;
      m_rr    <= P - 1;
      for (int i = 0; i < P; i++) m_cnt[i] <= 0;
    end else begin
      if (m_owner < 0) begin
        if (pick(m_rr, req_valid) >= 0) m_owner <= pick(m_rr, req_valid);
      end else if (req_valid[m_owner] && out_ready && req_last[m_owner]) begin
        m_owner <= -1;
        m_rr    <= m_owner;
      end
      for (int i = 0; i < P; i++) begin
        if (clr_stats) m_cnt[i] <= 0;
        else if (m_owner < 0 && pick(m_rr, req_valid) == i) m_cnt[i] <= m_cnt[i] + 1;
      end
    end
  end

  task automatic cyc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    out_ready = 1'b1;
    clr_stats = 1'b0;
  endtask

  task automatic apply_reset;
    rst = 1'b1;
    idle_inputs();
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle_inputs();
    cyc();
    req_valid = 3'b111;
    req_data  = {64'hC2, 64'hB1, 64'hA0};
    cyc();
    #1;
    tests++;
    if ({busy, out_valid, out_last, req_ready, out_src} !== 8'h00) begin
      fails++;
      $display("FAIL reset_ctrl: got busy=%b valid=%b last=%b ready=%b src=%0d, expected all 0", busy, out_valid, out_last, req_ready, out_src);
    end
    tests++;
    if (out_data !== 64'h0) begin
      fails++;
      $display("FAIL reset_data: got %h expected 0", out_data);
    end
    tests++;
    if (grant_cnt !== '0) begin
      fails++;
      $display("FAIL reset_cnt: got %h expected 0", grant_cnt);
    end
    rst = 1'b0;
    idle_inputs();
    cyc();
  endtask

  task automatic test_round_robin;
    int order[$];
    apply_reset();
    req_valid = 3'b111;
    req_last  = 3'b111;
    req_data  = {64'hC2, 64'hB1, 64'hA0};
    for (int c = 0; c < 6; c++) begin
      #1;
      tests++;
      if (out_valid !== (c % 2 == 1)) begin
        fails++;
        $display("FAIL rr_cadence c=%0d: got out_valid=%b expected %b", c, out_valid, (c % 2 == 1));
      end
      if (out_valid && out_ready) begin
        order.push_back(int'(out_src));
        tests++;
        if (out_data !== 64'hA0 + 64'h11 * out_src) begin
          fails++;
          $display("FAIL rr_data: got %h for src %0d", out_data, out_src);
        end
      end
      cyc();
    end
    tests++;
    if (order.size() != 3 || order[0] != 0 || order[1] != 1 || order[2] != 2) begin
      fails++;
      $display("FAIL rr_order: got %p expected '{0,1,2}", order);
    end
    tests++;
    if (grant_cnt !== {16'd1, 16'd1, 16'd1}) begin
      fails++;
      $display("FAIL rr_cnt: got %h expected 000100010001", grant_cnt);
    end
    idle_inputs();
    cyc();
  endtask

  task automatic test_wormhole_lock;
    apply_reset();
    req_valid = 3'b010;
    cyc();
    for (int k = 0; k < 4; k++) begin
      req_last[1] = (k == 3);
      req_data[1*DW +: DW] = 64'h1000 + 64'(k);
      if (k >= 1) begin
        req_valid[0] = 1'b1;
        req_data[0 +: DW] = 64'hDEAD;
      end
      #1;
      tests++;
      if (!busy || out_src !== 2'd1 || out_data !== 64'h1000 + 64'(k) || req_ready !== 3'b010 || out_last !== (k == 3)) begin
        fails++;
        $display("FAIL worm_flit%0d: got busy=%b src=%0d data=%h ready=%b last=%b", k, busy, out_src, out_data, req_ready, out_last);
      end
      cyc();
    end
    req_valid[1] = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0 || req_ready !== 3'b000) begin
      fails++;
      $display("FAIL worm_bubble: got busy=%b ready=%b expected 0/000", busy, req_ready);
    end
    cyc();
    #1;
    tests++;
    if (busy !== 1'b1 || out_src !== 2'd0 || out_data !== 64'hDEAD) begin
      fails++;
      $display("FAIL worm_next: got busy=%b src=%0d data=%h expected 1/0/dead", busy, out_src, out_data);
    end
    req_last[0] = 1'b1;
    cyc();
    idle_inputs();
    cyc();
  endtask

  task automatic test_backpressure;
    logic [DW-1:0] got[$];
    logic pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    int k = 0;
    apply_reset();
    req_valid = 3'b100;
    cyc();
    for (int c = 0; c < 5; c++) begin
      req_data[2*DW +: DW] = 64'h2000 + 64'(k);
      req_last[2] = (k == 2);
      out_ready = pat[c];
      #1;
      tests++;
      if (out_data !== 64'h2000 + 64'(k) || req_ready !== {out_ready, 2'b00}) begin
        fails++;
        $display("FAIL bp_c%0d: got data=%h ready=%b expected %h/%b", c, out_data, req_ready, 64'h2000 + 64'(k), {out_ready, 2'b00});
      end
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        k++;
      end
      cyc();
    end
    tests++;
    if (got.size() != 3 || got[0] !== 64'h2000 || got[1] !== 64'h2001 || got[2] !== 64'h2002) begin
      fails++;
      $display("FAIL bp_stream: got %p expected 2000,2001,2002", got);
    end
    req_valid = '0;
    out_ready = 1'b1;
    #1;
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL bp_end: got busy=%b expected 0", busy);
    end
    cyc();
  endtask

  task automatic test_drop_valid;
    apply_reset();
    req_valid = 3'b100;
    cyc();
    req_data[2*DW +: DW] = 64'h3000;
    #1;
    tests++;
    if (out_valid !== 1'b1 || out_data !== 64'h3000) begin
      fails++;
      $display("FAIL drop_first: got valid=%b data=%h", out_valid, out_data);
    end
    cyc();
    for (int c = 0; c < 3; c++) begin
      req_valid = 3'b011;
      req_data  = {64'h5555, 64'h4444, 64'h3333};
      #1;
      tests++;
      if (busy !== 1'b1 || out_valid !== 1'b0 || req_ready[1:0] !== 2'b00 || out_data !== 64'h0 || out_src !== 2'd2) begin
        fails++;
        $display("FAIL drop_hold%0d: got busy=%b valid=%b ready=%b data=%h src=%0d", c, busy, out_valid, req_ready, out_data, out_src);
      end
      cyc();
    end
    req_valid = 3'b111;
    req_last  = 3'b100;
    req_data[2*DW +: DW] = 64'h3001;
    #1;
    tests++;
    if (out_valid !== 1'b1 || out_data !== 64'h3001 || out_last !== 1'b1) begin
      fails++;
      $display("FAIL drop_resume: got valid=%b data=%h last=%b", out_valid, out_data, out_last);
    end
    cyc();
    idle_inputs();
    #1;
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL drop_end: got busy=%b expected 0", busy);
    end
    cyc();
  endtask

  task automatic test_saturation;
    apply_reset();
    req_valid = 3'b001;
    req_last  = 3'b001;
    for (int c = 0; c < 10; c++) cyc();
    #1;
    tests++;
    if (grant_cnt[0 +: CW] !== 16'd5 || s_grant_cnt[0 +: CWS] !== 2'b11) begin
      fails++;
      $display("FAIL sat_hold: got wide=%0d narrow=%0d expected 5/3", grant_cnt[0 +: CW], s_grant_cnt[0 +: CWS]);
    end
    clr_stats = 1'b1;
    cyc();
    clr_stats = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b1 || grant_cnt !== '0 || s_grant_cnt !== '0) begin
      fails++;
      $display("FAIL sat_clr: got busy=%b wide=%h narrow=%h expected 1/0/0", busy, grant_cnt, s_grant_cnt);
    end
    cyc();
    idle_inputs();
    cyc();
  endtask

  task automatic test_reset_mid_packet;
    apply_reset();
    req_valid = 3'b010;
    cyc();
    req_data[1*DW +: DW] = 64'h4000;
    #1;
    tests++;
    if (busy !== 1'b1 || out_src !== 2'd1) begin
      fails++;
      $display("FAIL rstmid_grant: got busy=%b src=%0d expected 1/1", busy, out_src);
    end
    cyc();
    rst = 1'b1;
    req_valid = 3'b011;
    cyc();
    #1;
    tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || grant_cnt !== '0) begin
      fails++;
      $display("FAIL rstmid_clear: got busy=%b valid=%b cnt=%h", busy, out_valid, grant_cnt);
    end
    rst = 1'b0;
    cyc();
    #1;
    tests++;
    if (busy !== 1'b1 || out_src !== 2'd0) begin
      fails++;
      $display("FAIL rstmid_prio: got busy=%b src=%0d expected 1/0", busy, out_src);
    end
    req_last = 3'b011;
    cyc();
    idle_inputs();
    cyc();
  endtask

  task automatic test_random;
    logic            e_busy, e_valid, e_last;
    logic [DW-1:0]   e_data;
    logic [P-1:0]    e_ready;
    logic [SW-1:0]   e_src;
    logic [P*CW-1:0] e_cnt;
    logic [P*CWS-1:0] e_scnt;
    apply_reset();
    for (int n = 0; n < 3000; n++) begin
      req_valid = P'($urandom);
      for (int i = 0; i < P; i++) begin
        req_last[i] = ($urandom_range(0, 3) == 0);
        req_data[i*DW +: DW] = {$urandom, $urandom};
      end
      out_ready = ($urandom_range(0, 3) != 0);
      clr_stats = ($urandom_range(0, 63) == 0);
      rst       = ($urandom_range(0, 499) == 0);
      #1;
      e_busy  = (m_owner >= 0);
      e_valid = 1'b0;
      e_last  = 1'b0;
      e_data  = '0;
      e_ready = '0;
      e_src   = '0;
      if (e_busy) begin
        e_src   = SW'(m_owner);
        e_valid = req_valid[m_owner];
        e_ready[m_owner] = out_ready;
        if (e_valid) begin
          e_data = req_data[m_owner*DW +: DW];
          e_last = req_last[m_owner];
        end
      end
      for (int i = 0; i < P; i++) begin
        e_cnt[i*CW +: CW]    = (m_cnt[i] > 65535) ? 16'hFFFF : CW'(m_cnt[i]);
        e_scnt[i*CWS +: CWS] = (m_cnt[i] > 3) ? 2'b11 : CWS'(m_cnt[i]);
      end
      tests++;
      if ({busy, out_valid, out_last, req_ready, out_src} !== {e_busy, e_valid, e_last, e_ready, e_src}) begin
        fails++;
        $display("FAIL rand_ctrl n=%0d: got busy=%b valid=%b last=%b ready=%b src=%0d expected %b/%b/%b/%b/%0d",
                 n, busy, out_valid, out_last, req_ready, out_src, e_busy, e_valid, e_last, e_ready, e_src);
      end
      tests++;
      if (out_data !== e_data) begin
        fails++;
        $display("FAIL rand_data n=%0d: got %h expected %h", n, out_data, e_data);
      end
      tests++;
      if (grant_cnt !== e_cnt || s_grant_cnt !== e_scnt) begin
        fails++;
        $display("FAIL rand_cnt n=%0d: got %h/%h expected %h/%h", n, grant_cnt, s_grant_cnt, e_cnt, e_scnt);
      end
      cyc();
    end
    rst = 1'b0;
    idle_inputs();
    cyc();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_wormhole_lock();
    test_backpressure();
    test_drop_valid();
    test_saturation();
    test_reset_mid_packet();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
